// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants: the parity selector encoding,
//               the receiver FSM state encoding and the minimum bit divisor.
//               parity_enabled() reports whether a parity bit is on the wire.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int UART_MIN_DIV = 4;

    function automatic logic parity_enabled(input parity_e p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_if
// Description : One-deep valid/ready output buffer of the UART receiver.
//               master : receiver side (drives data, valid and error flags)
//               slave  : consumer side (drives ready)
//   o_rx_data        received word
//   o_rx_valid       buffer holds an unconsumed word
//   i_rx_ready       consumer accepts the word
//   o_framing_error  stop bit was low (qualified by o_rx_valid)
//   o_parity_error   parity mismatch (qualified by o_rx_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_rx_data;
    logic                 o_rx_valid;
    logic                 i_rx_ready;
    logic                 o_framing_error;
    logic                 o_parity_error;

    modport master (
        output o_rx_data,
        output o_rx_valid,
        output o_framing_error,
        output o_parity_error,
        input  i_rx_ready
    );

    modport slave (
        input  o_rx_data,
        input  o_rx_valid,
        input  o_framing_error,
        input  o_parity_error,
        output i_rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : Multi-flop synchroniser for the asynchronous serial line.
//               Flops preset to 1 so the idle-high line never shows a false
//               falling edge after reset.
//   clk, rst   clock, asynchronous active-high reset
//   i_async    asynchronous input
//   o_sync     synchronised output (SYNC_STAGES cycles of delay)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : UART receiver. Deserialises start bit, DATA_BITS data bits
//               LSB first, optional parity bit and one stop bit from the
//               idle-high line; delivers words through a one-deep valid/ready
//               buffer with framing/parity flags and an overrun pulse.
//   clk, rst          clock, asynchronous active-high reset
//   i_rx              serial line (asynchronous, idle high)
//   i_baud_divisor    clocks per bit (clamped to MIN_DIV, latched per frame)
//   i_parity_type     00/11 none, 01 even, 10 odd
//   rx_if             output buffer (master modport)
//   o_overrun_error   1-cycle pulse when a completed frame is dropped
//   o_busy            FSM not idle
//   o_break           (only with UART_RX_BREAK_DETECT_EN) 1-cycle pulse on an
//                     all-zero frame; such a frame is not buffered
// Build option: define UART_RX_BREAK_DETECT_EN to enable break detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DIV     = UART_MIN_DIV
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_rx,
    input  wire logic [15:0] i_baud_divisor,
    input  wire logic [1:0]  i_parity_type,
    uart_rx_frame_if.master  rx_if,
    output logic             o_overrun_error,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic             o_break,
`endif
    output logic             o_busy
);

    // ------------------------------------------------------------------
    // Line synchroniser and edge detect
    // ------------------------------------------------------------------
    logic w_rx_s;
    logic r_rx_prev;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_prev <= 1'b1;
        else     r_rx_prev <= w_rx_s;
    end

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    rx_state_e            r_state;
    rx_state_e            w_state_next;
    logic [15:0]          r_div;
    logic [15:0]          r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    parity_e              r_par_type;

    logic [15:0] w_div;
    logic        w_fall;
    logic        w_expire;
    logic        w_last_bit;
    logic        w_par_en;

    assign w_div      = (i_baud_divisor < 16'(MIN_DIV)) ? 16'(MIN_DIV) : i_baud_divisor;
    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_expire   = (r_cnt == 16'd0);
    assign w_last_bit = (r_bit_idx == 4'(DATA_BITS - 1));
    assign w_par_en   = parity_enabled(r_par_type);

    // FSM control strobes
    logic w_start;      // start edge seen in IDLE
    logic w_data_go;    // start bit confirmed low at mid-bit
    logic w_sample;     // mid-bit data sample
    logic w_par_cap;    // mid-bit parity sample
    logic w_complete;   // mid-stop-bit sample, frame done

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_data_go    = 1'b0;
        w_sample     = 1'b0;
        w_par_cap    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_start      = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_expire) begin
                    if (!w_rx_s) begin
                        w_data_go    = 1'b1;
                        w_state_next = DATA;
                    end else begin
                        // Line went back high: a glitch, not a frame
                        w_state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_sample = 1'b1;
                    if (w_last_bit) w_state_next = w_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_expire) begin
                    w_par_cap    = 1'b1;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_expire) begin
                    // Back to IDLE at mid-stop so a following start edge is caught
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bit timer, divisor/parity latches and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= 16'd0;
            r_cnt      <= 16'd0;
            r_bit_idx  <= 4'd0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_type <= PAR_NONE;
        end else begin
            if (w_start) begin
                // First sample lands half a bit in: the middle of the start bit
                r_div      <= w_div;
                r_cnt      <= (w_div >> 1) - 16'd1;
                r_par_type <= parity_e'(i_parity_type);
                r_par_bit  <= 1'b0;
            end else if (r_state != IDLE) begin
                r_cnt <= w_expire ? (r_div - 16'd1) : (r_cnt - 16'd1);
            end

            if (w_data_go)     r_bit_idx <= 4'd0;
            else if (w_sample) r_bit_idx <= r_bit_idx + 4'd1;

            // LSB arrives first, so shifting in at the MSB ends LSB-aligned
            if (w_sample)  r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (w_par_cap) r_par_bit <= w_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame completion and output buffer
    // ------------------------------------------------------------------
    logic w_frame_fe;
    logic w_frame_pe;
    logic w_deliver;

    assign w_frame_fe = ~w_rx_s;
    // Data plus parity must have even weight for even parity, odd for odd
    assign w_frame_pe = w_par_en &&
                        (((^r_shift) ^ r_par_bit) != (r_par_type == PAR_ODD));

`ifdef UART_RX_BREAK_DETECT_EN
    logic w_is_break;
    logic r_break;
    assign w_is_break = (r_shift == '0) && !(w_par_en && r_par_bit) && !w_rx_s;
    assign w_deliver  = w_complete && !w_is_break;
    assign o_break    = r_break;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_break <= 1'b0;
        else     r_break <= w_complete && w_is_break;
    end
`else
    assign w_deliver  = w_complete;
`endif

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_fe;
    logic                 r_pe;
    logic                 r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_fe      <= 1'b0;
            r_pe      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && rx_if.i_rx_ready) r_valid <= 1'b0;
            // A refill in the same cycle as a drain wins, keeping valid high
            if (w_deliver) begin
                if (!r_valid || rx_if.i_rx_ready) begin
                    r_data  <= r_shift;
                    r_fe    <= w_frame_fe;
                    r_pe    <= w_frame_pe;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign rx_if.o_rx_data       = r_data;
    assign rx_if.o_rx_valid      = r_valid;
    assign rx_if.o_framing_error = r_fe;
    assign rx_if.o_parity_error  = r_pe;
    assign o_overrun_error       = r_overrun;
    assign o_busy                = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Self-checking bench for uart_rx_frame. Frames are built bit by
//               bit from their definition; expected words, flags, overrun and
//               break events come from the frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        rx      = 1'b1;
    logic [15:0] divisor = 16'd16;
    logic [1:0]  ptype   = 2'b00;
    logic        overrun;
    logic        busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic        brk;
`endif

    uart_rx_frame_if #(.DATA_BITS(DW)) rx_if ();

    uart_rx_frame #(
        .DATA_BITS   (DW),
        .SYNC_STAGES (SYNC),
        .MIN_DIV     (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rx            (rx),
        .i_baud_divisor  (divisor),
        .i_parity_type   (ptype),
        .rx_if           (rx_if),
        .o_overrun_error (overrun),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_break         (brk),
`endif
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    // Event log gathered at the falling edge
    logic [DW-1:0] got_data[$];
    bit            got_fe[$];
    bit            got_pe[$];
    int            ovr_cycles = 0;
    int            brk_cycles = 0;
    int            rise_cyc   = 0;
    bit            prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rx_if.o_rx_valid && rx_if.i_rx_ready) begin
            got_data.push_back(rx_if.o_rx_data);
            got_fe.push_back(rx_if.o_framing_error);
            got_pe.push_back(rx_if.o_parity_error);
        end
        if (overrun) ovr_cycles = ovr_cycles + 1;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk) brk_cycles = brk_cycles + 1;
`endif
        if (rx_if.o_rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_if.o_rx_valid;
    end

    task automatic clear_log();
        got_data.delete();
        got_fe.delete();
        got_pe.delete();
        ovr_cycles = 0;
        brk_cycles = 0;
    endtask

    // Drive a line level for n clocks; entered and left at posedge+1
    task automatic hold(input bit v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int bitclk, input bit has_par,
                              input bit pbit, input bit stop, input int gap, input bit scramble);
        hold(1'b0, bitclk);
        for (int i = 0; i < DW; i++) begin
            hold(d[i], bitclk);
            if (scramble && i == 0) divisor = 16'($urandom_range(0, 65535));
        end
        if (has_par) hold(pbit, bitclk);
        hold(stop, bitclk);
        if (gap > 0) hold(1'b1, gap * bitclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        rx_if.i_rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rx_if.o_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_if.o_rx_valid); end
        checks++; if (rx_if.o_rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_if.o_rx_data); end
        checks++; if (rx_if.o_framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", rx_if.o_framing_error); end
        checks++; if (rx_if.o_parity_error !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", rx_if.o_parity_error); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || rx_if.o_rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy %b valid %b want 0 0", busy, rx_if.o_rx_valid); end
    endtask

    task automatic test_basic();
        int start_cyc;
        int exp_lat;
        divisor = 16'd16; ptype = 2'b00;
        clear_log();
        start_cyc = cyc;
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        exp_lat = (1 + DW) * 16 + 16 / 2 + SYNC + 1;
        checks++; if (got_data.size() != 1) begin errors++; $display("FAIL basic_count: got %0d words want 1", got_data.size()); end
        else begin
            checks++; if (got_data[0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got_data[0]); end
            checks++; if (got_fe[0] !== 1'b0 || got_pe[0] !== 1'b0) begin errors++; $display("FAIL basic_flags: fe %b pe %b want 0 0", got_fe[0], got_pe[0]); end
        end
        checks++; if (rise_cyc - start_cyc != exp_lat) begin errors++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - start_cyc, exp_lat); end
    endtask

    task automatic test_min_div();
        int start_cyc;
        int exp_lat;
        logic [DW-1:0] d;
        d = DW'($urandom);
        divisor = 16'd2; ptype = 2'b00;
        clear_log();
        start_cyc = cyc;
        send_frame(d, 4, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        exp_lat = (1 + DW) * 4 + 4 / 2 + SYNC + 1;
        checks++; if (got_data.size() != 1 || got_data[0] !== d) begin errors++; $display("FAIL clamp_data: words %0d first %h want 1 %h", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx, d); end
        checks++; if (rise_cyc - start_cyc != exp_lat) begin errors++; $display("FAIL clamp_latency: got %0d want %0d", rise_cyc - start_cyc, exp_lat); end
    endtask

    task automatic test_parity_even();
        divisor = 16'd16; ptype = 2'b01;
        clear_log();
        send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        send_frame(8'h01, 16, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL parity_count: got %0d want 2", got_data.size()); end
        else begin
            checks++; if (got_data[0] !== 8'h01 || got_pe[0] !== 1'b0 || got_fe[0] !== 1'b0) begin errors++; $display("FAIL parity_good: data %h pe %b fe %b want 01 0 0", got_data[0], got_pe[0], got_fe[0]); end
            checks++; if (got_data[1] !== 8'h01 || got_pe[1] !== 1'b1) begin errors++; $display("FAIL parity_bad: data %h pe %b want 01 1", got_data[1], got_pe[1]); end
        end
        ptype = 2'b00;
    endtask

    task automatic test_framing();
        divisor = 16'd16; ptype = 2'b00;
        clear_log();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL framing_count: got %0d want 2", got_data.size()); end
        else begin
            checks++; if (got_data[0] !== 8'h3C || got_fe[0] !== 1'b1 || got_pe[0] !== 1'b0) begin errors++; $display("FAIL framing_bad: data %h fe %b pe %b want 3c 1 0", got_data[0], got_fe[0], got_pe[0]); end
            checks++; if (got_data[1] !== 8'h55 || got_fe[1] !== 1'b0) begin errors++; $display("FAIL framing_next: data %h fe %b want 55 0", got_data[1], got_fe[1]); end
        end
    endtask

    task automatic test_back_to_back();
        divisor = 16'd16; ptype = 2'b00;
        clear_log();
        rx_if.i_rx_ready = 1'b0;
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 16, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        @(negedge clk);
        checks++; if (rx_if.o_rx_valid !== 1'b1 || rx_if.o_rx_data !== 8'h11) begin errors++; $display("FAIL overrun_hold: valid %b data %h want 1 11", rx_if.o_rx_valid, rx_if.o_rx_data); end
        checks++; if (ovr_cycles != 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles want 1", ovr_cycles); end
        @(posedge clk); #1;
        rx_if.i_rx_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++; if (got_data.size() != 1 || got_data[0] !== 8'h11) begin errors++; $display("FAIL overrun_drain: words %0d first %h want 1 11", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx); end
        checks++; if (rx_if.o_rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_empty: valid %b want 0", rx_if.o_rx_valid); end
    endtask

    task automatic test_glitch_reset();
        logic [DW-1:0] d;
        d = 8'h7E;
        divisor = 16'd434; ptype = 2'b00;
        clear_log();
        hold(1'b0, 3);
        hold(1'b1, 2 * 434);
        checks++; if (busy !== 1'b0 || got_data.size() != 0 || rx_if.o_rx_valid !== 1'b0) begin errors++; $display("FAIL glitch: busy %b words %0d valid %b want 0 0 0", busy, got_data.size(), rx_if.o_rx_valid); end
        // Start of 0x7E, then reset partway through the data bits
        hold(1'b0, 434);
        hold(d[0], 434);
        hold(d[1], 434);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", busy); end
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        hold(1'b1, 12 * 434);
        checks++; if (got_data.size() != 0 || rx_if.o_rx_valid !== 1'b0 || ovr_cycles != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort: words %0d valid %b ovr %0d busy %b want 0 0 0 0", got_data.size(), rx_if.o_rx_valid, ovr_cycles, busy); end
        send_frame(d, 434, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        checks++; if (got_data.size() != 1 || got_data[0] !== d || got_fe[0] !== 1'b0 || got_pe[0] !== 1'b0) begin errors++; $display("FAIL after_abort: words %0d first %h want 1 7e clean", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d[$];
        bit            exp_fe[$];
        bit            exp_pe[$];
        int            exp_brk;
        int            raw, bc, gap, ones;
        logic [DW-1:0] d;
        bit            en, pbit, stop, odd;
        exp_brk = 0;
        clear_log();
        for (int n = 0; n < 24; n++) begin
            raw  = $urandom_range(0, 24);
            bc   = (raw < 4) ? 4 : raw;
            d    = DW'($urandom);
            if ($urandom_range(0, 7) == 0) d = '0;
            ptype   = 2'($urandom_range(0, 3));
            divisor = 16'(raw);
            en   = (ptype == 2'b01) || (ptype == 2'b10);
            odd  = (ptype == 2'b10);
            ones = $countones(d);
            pbit = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
            if ($urandom_range(0, 9) == 0) pbit = !pbit;
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            if (n == 23) gap = 2;
            send_frame(d, bc, en, pbit, stop, gap, ($urandom_range(0, 1) == 1));
            ones = ones + (en ? int'(pbit) : 0);
`ifdef UART_RX_BREAK_DETECT_EN
            if (d == '0 && !(en && pbit) && !stop) begin
                exp_brk++;
                continue;
            end
`endif
            exp_d.push_back(d);
            exp_fe.push_back(!stop);
            exp_pe.push_back(en && ((ones % 2) != (odd ? 1 : 0)));
        end
        checks++; if (got_data.size() != exp_d.size()) begin errors++; $display("FAIL random_count: got %0d want %0d", got_data.size(), exp_d.size()); end
        else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_d[i] || got_fe[i] !== exp_fe[i] || got_pe[i] !== exp_pe[i]) begin
                    errors++;
                    $display("FAIL random_word%0d: got %h fe %b pe %b want %h fe %b pe %b", i, got_data[i], got_fe[i], got_pe[i], exp_d[i], exp_fe[i], exp_pe[i]);
                end
            end
        end
        checks++; if (brk_cycles != exp_brk || ovr_cycles != 0) begin errors++; $display("FAIL random_events: break %0d ovr %0d want %0d 0", brk_cycles, ovr_cycles, exp_brk); end
        ptype = 2'b00;
    endtask

    task automatic test_line_low();
        divisor = 16'd16; ptype = 2'b00;
        clear_log();
        hold(1'b0, 12 * 16);
        hold(1'b1, 3 * 16);
`ifdef UART_RX_BREAK_DETECT_EN
        checks++; if (brk_cycles != 1) begin errors++; $display("FAIL break_pulse: got %0d cycles want 1", brk_cycles); end
        checks++; if (got_data.size() != 0 || rx_if.o_rx_valid !== 1'b0) begin errors++; $display("FAIL break_no_word: words %0d valid %b want 0 0", got_data.size(), rx_if.o_rx_valid); end
`else
        checks++; if (got_data.size() != 1) begin errors++; $display("FAIL low_count: got %0d want 1", got_data.size()); end
        else begin
            checks++; if (got_data[0] !== 8'h00 || got_fe[0] !== 1'b1 || got_pe[0] !== 1'b0) begin errors++; $display("FAIL low_word: data %h fe %b pe %b want 00 1 0", got_data[0], got_fe[0], got_pe[0]); end
        end
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_min_div();
        test_parity_even();
        test_framing();
        test_back_to_back();
        test_glitch_reset();
        test_random();
        test_line_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
